// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-press debounce.
// Keeps the two most recent hex codes for a two-digit display.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 10000,
  parameter int unsigned DEBOUNCE_CYC = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] s_new,
  output logic [3:0] s_old,
  output logic       key_valid
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYC);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync_q, rows_s_q;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]       s_new_q, s_new_d;
  logic [3:0]       s_old_q, s_old_d;
  logic             kv_q, kv_d;

  logic [3:0] low;
  logic       one_low;
  logic [1:0] low_idx;
  logic       row_hi;
  logic [3:0] key_code;

  assign low     = ~rows_s_q;
  // Exactly one row low; multi-row presses are ambiguous and ignored.
  assign one_low = (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);
  assign row_hi  = rows_s_q[row_q];

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    key_code = 4'h0;
    unique case ({row_q, col_q})
      4'b00_00: key_code = 4'h1;
      4'b00_01: key_code = 4'h2;
      4'b00_10: key_code = 4'h3;
      4'b00_11: key_code = 4'hA;
      4'b01_00: key_code = 4'h4;
      4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h6;
      4'b01_11: key_code = 4'hB;
      4'b10_00: key_code = 4'h7;
      4'b10_01: key_code = 4'h8;
      4'b10_10: key_code = 4'h9;
      4'b10_11: key_code = 4'hC;
      4'b11_00: key_code = 4'hE;
      4'b11_01: key_code = 4'h0;
      4'b11_10: key_code = 4'hF;
      4'b11_11: key_code = 4'hD;
      default:  key_code = 4'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    s_new_d    = s_new_q;
    s_old_d    = s_old_q;
    kv_d       = 1'b0;
    unique case (state_q)
      StScan: begin
        if (scan_cnt_q == ScanLast) begin
          scan_cnt_d = '0;
          if (one_low) begin
            row_d     = low_idx;
            deb_cnt_d = '0;
            state_d   = StDebounce;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + ScanW'(1);
        end
      end
      StDebounce: begin
        if (row_hi) begin
          state_d    = StScan;
          scan_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          s_old_d = s_new_q;
          s_new_d = key_code;
          kv_d    = 1'b1;
          state_d = StHeld;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      StHeld: begin
        if (row_hi) begin
          state_d   = StRelease;
          deb_cnt_d = '0;
        end
      end
      StRelease: begin
        if (!row_hi) begin
          state_d = StHeld;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StScan;
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StScan;
      sync_q     <= 4'hF;
      rows_s_q   <= 4'hF;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      s_new_q    <= 4'h0;
      s_old_q    <= 4'h0;
      kv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= rows;
      rows_s_q   <= sync_q;
      col_q      <= col_d;
      row_q      <= row_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      s_new_q    <= s_new_d;
      s_old_q    <= s_old_d;
      kv_q       <= kv_d;
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign s_new     = s_new_q;
  assign s_old     = s_old_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a run-length reference model,
// directed scenarios followed by random press/release episodes.
module tb_keypad_scanner;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned DebCyc  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] s_new;
  logic [3:0] s_old;
  logic       key_valid;
  logic [15:0] pressed = '0;  // bit r*4+c

  int vectors = 0;
  int miscompares = 0;
  int kv_seen = 0;

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model: run-lengths of the latched row level, not a state machine.
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_new = 4'h0, m_old = 4'h0;
  int m_col = 0, m_dwell = 0, m_run = 0, m_lrow = 0;
  bit m_latched = 1'b0, m_acc = 1'b0, m_kv = 1'b0;

  keypad_scanner #(
    .SCAN_DIV     (ScanDiv),
    .DEBOUNCE_CYC (DebCyc)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .s_new     (s_new),
    .s_old     (s_old),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!cols[c] && pressed[r*4+c]) rows[r] = 1'b0;
      end
    end
  end

  function automatic logic [3:0] model_rows();
    logic [3:0] v = 4'hF;
    for (int r = 0; r < 4; r++) if (pressed[r*4+m_col]) v[r] = 1'b0;
    return v;
  endfunction

  task automatic model_step();
    logic [3:0] rin;
    logic [3:0] rs;
    int nlow;
    int idx;
    rin  = model_rows();
    rs   = m_s2;
    m_kv = 1'b0;
    if (!reset) begin
      m_col = 0; m_dwell = 0; m_run = 0; m_latched = 1'b0; m_acc = 1'b0;
      m_new = 4'h0; m_old = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF;
    end else begin
      if (!m_latched) begin
        m_dwell++;
        if (m_dwell == ScanDiv) begin
          m_dwell = 0;
          nlow = 0;
          idx = 0;
          for (int r = 0; r < 4; r++) if (!rs[r]) begin nlow++; idx = r; end
          if (nlow == 1) begin
            m_latched = 1'b1; m_lrow = idx; m_run = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
      end else if (!m_acc) begin
        if (rs[m_lrow]) begin
          m_latched = 1'b0; m_dwell = 0;
        end else begin
          m_run++;
          if (m_run == DebCyc + 1) begin
            m_acc = 1'b1; m_old = m_new; m_new = keymap[m_lrow*4+m_col]; m_kv = 1'b1; m_run = 0;
          end
        end
      end else begin
        if (rs[m_lrow]) begin
          m_run++;
          if (m_run == DebCyc + 1) begin
            m_latched = 1'b0; m_acc = 1'b0; m_run = 0; m_dwell = 0; m_col = (m_col + 1) % 4;
          end
        end else begin
          m_run = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = rin;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [3:0] exp_cols;
    @(posedge clk);
    #1;
    model_step();
    if (key_valid === 1'b1) kv_seen++;
    exp_cols = ~(4'b0001 << m_col);
    chk("cols", {4'h0, cols}, {4'h0, exp_cols});
    chk("key_valid", {7'h0, key_valid}, {7'h0, m_kv});
    chk("s_new", {4'h0, s_new}, {4'h0, m_new});
    chk("s_old", {4'h0, s_old}, {4'h0, m_old});
  endtask

  task automatic wait_latched(input int budget);
    int n = 0;
    while (!m_latched && n < budget) begin cycle(); n++; end
    chk("wait_latched", {7'h0, m_latched}, 8'h01);
  endtask

  task automatic wait_accepted(input int budget);
    int n = 0;
    while (!m_acc && n < budget) begin cycle(); n++; end
    chk("wait_accepted", {7'h0, m_acc}, 8'h01);
  endtask

  task automatic wait_unlatched(input int budget);
    int n = 0;
    while (m_latched && n < budget) begin cycle(); n++; end
    chk("wait_unlatched", {7'h0, m_latched}, 8'h00);
  endtask

  initial begin
    int base;
    int k;

    // Reset held for three cycles, then free-running column rotation.
    reset = 1'b0;
    repeat (3) cycle();
    chk("rst_cols", {4'h0, cols}, 8'h0E);
    chk("rst_kv", {7'h0, key_valid}, 8'h00);
    reset = 1'b1;
    repeat (16) cycle();

    // Clean press of '5'.
    base = kv_seen;
    pressed = 16'h1 << 5;
    repeat (40) cycle();
    chk("t2_s_new", {4'h0, s_new}, 8'h05);
    chk("t2_cols_held", {4'h0, cols}, 8'h0D);
    pressed = '0;
    repeat (30) cycle();
    chk("t2_pulses", 8'(kv_seen - base), 8'd1);
    chk("t2_s_old", {4'h0, s_old}, 8'h00);

    // 'A' then '7'.
    base = kv_seen;
    pressed = 16'h1 << 3;
    repeat (40) cycle();
    pressed = '0;
    repeat (30) cycle();
    pressed = 16'h1 << 8;
    repeat (40) cycle();
    pressed = '0;
    repeat (30) cycle();
    chk("t3_pulses", 8'(kv_seen - base), 8'd2);
    chk("t3_s_new", {4'h0, s_new}, 8'h07);
    chk("t3_s_old", {4'h0, s_old}, 8'h0A);

    // Bouncing '9' never accepted; scanning resumes on column 2.
    base = kv_seen;
    pressed = 16'h1 << 10;
    wait_latched(64);
    repeat (2) cycle();
    pressed = '0;
    wait_unlatched(16);
    chk("t4_cols", {4'h0, cols}, 8'h0B);
    chk("t4_pulses", 8'(kv_seen - base), 8'd0);
    chk("t4_s_new", {4'h0, s_new}, 8'h07);

    // Held '0' with '3' pressed meanwhile and a bouncing release.
    base = kv_seen;
    pressed = 16'h1 << 13;
    wait_accepted(80);
    pressed = pressed | (16'h1 << 2);
    repeat (10) cycle();
    pressed = '0;
    repeat (3) cycle();
    pressed = 16'h1 << 13;
    repeat (10) cycle();
    pressed = '0;
    repeat (30) cycle();
    chk("t5_pulses", 8'(kv_seen - base), 8'd1);
    chk("t5_s_new", {4'h0, s_new}, 8'h00);
    chk("t5_s_old", {4'h0, s_old}, 8'h07);

    // Two rows low in one column: no acceptance.
    base = kv_seen;
    pressed = (16'h1 << 2) | (16'h1 << 6);
    repeat (40) cycle();
    chk("t6a_pulses", 8'(kv_seen - base), 8'd0);
    pressed = '0;
    repeat (10) cycle();

    // Reset in the middle of debouncing '6'.
    pressed = 16'h1 << 6;
    wait_latched(64);
    repeat (4) cycle();
    reset = 1'b0;
    cycle();
    chk("t6b_cols", {4'h0, cols}, 8'h0E);
    chk("t6b_s_new", {4'h0, s_new}, 8'h00);
    chk("t6b_s_old", {4'h0, s_old}, 8'h00);
    chk("t6b_kv", {7'h0, key_valid}, 8'h00);
    reset = 1'b1;
    pressed = '0;
    repeat (5) cycle();

    // Random press/release episodes, occasionally with a second key or a reset.
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(15));
      pressed = 16'h1 << k;
      if ($urandom_range(3) == 0) pressed = pressed | (16'h1 << $urandom_range(15));
      repeat ($urandom_range(40, 1)) cycle();
      pressed = '0;
      repeat ($urandom_range(30, 1)) cycle();
      if ($urandom_range(19) == 0) begin
        reset = 1'b0;
        cycle();
        reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and debounces each press.
- Registers exactly one hex code per physical press and keeps the two most recent codes.
- Sits directly upstream of the two-digit display time-multiplexer: s_old drives its s1 (left digit), s_new drives its s2 (right digit).
- Single clock domain. Row inputs are asynchronous and are synchronized inside the block.

Parameters:
SCAN_DIV, 10000, clk cycles each column stays driven while scanning (min 4)
DEBOUNCE_CYC, 240000, clk cycles a row level must hold stable to accept a press or a release (min 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rows  input  4  keypad row lines, active-low (pulled up), asynchronous
cols  output  4  keypad column drive, active-low, one-hot-zero
s_new  output  4  hex code of most recent accepted key
s_old  output  4  hex code of previously accepted key
key_valid  output  1  one-cycle pulse when a key is accepted

Behaviour:
- Reset and clock: clock clk; reset is synchronous, active-low. On any clk edge with reset=0:
  - cols=4'b1110 (column 0 active); s_new=0, s_old=0, key_valid=0.
  - state=SCAN; all counters=0; synchronizer flops=4'hF.
  - This applies in any state, including mid-DEBOUNCE or HELD.
- Synchronizer: rows passes through 2 flops to give rows_s. All decisions use rows_s only.
- Key map, as [row][col], row/col index 0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - scan_cnt counts 0..SCAN_DIV-1. rows_s is sampled only when scan_cnt==SCAN_DIV-1, so lines have settled.
  - Sample rows_s==4'hF: cols rotates to the next column (0->1->2->3->0), scan_cnt=0.
  - Exactly one bit low: latch row and column indices, go DEBOUNCE, deb_cnt=0, cols frozen.
  - Two or more bits low: treated as no key; rotate as normal.
- DEBOUNCE:
  - cols held. deb_cnt increments each cycle.
  - Latched row reads 1 at any cycle before completion: go SCAN, scan_cnt=0, same column, no output change.
  - Latched row still 0 when deb_cnt==DEBOUNCE_CYC-1: on that edge s_old<=s_new, s_new<=code, key_valid=1 for that one cycle, go HELD.
  - key_valid therefore rises DEBOUNCE_CYC cycles after DEBOUNCE entry.
- HELD:
  - cols held; stay while latched row is 0.
  - Other rows, and keys in other columns, are ignored.
  - Latched row 1: go RELEASE, deb_cnt=0.
- RELEASE:
  - Latched row must read 1 for DEBOUNCE_CYC consecutive cycles.
  - Reads 0 before completion: back to HELD, no new key.
  - Completion: go SCAN, advance to next column, scan_cnt=0.
- Invariants:
  - key_valid is never high two consecutive cycles.
  - Only one key_valid per press-release cycle.
  - s_new/s_old change only together with key_valid.
- Counter widths: $clog2 of the parameter. No wrap-around is reachable, since each counter clears at its terminal value.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_CYC=8, with a keypad model that pulls row r low only while cols[c]==0 and key (r,c) is pressed.
1. Reset:
   - Stimulus: hold reset=0 for 3 cycles, no keys.
   - Response: cols=1110, s_new=0, s_old=0, key_valid=0.
   - After release of reset: cols steps 1110->1101->1011->0111->1110, every 4 cycles.
2. Clean press of '5' (r1,c1), held 40 cycles:
   - key_valid pulses once, 8 cycles after DEBOUNCE entry.
   - s_new=5, s_old=0.
   - cols stays 1101 until release plus 8 stable cycles, then scanning resumes.
3. Sequential keys:
   - Stimulus: press/release 'A' (r0,c3), then '7' (r2,c0).
   - Response: two pulses total; final s_new=7, s_old=A.
4. Press bounce:
   - Stimulus: '9' row low 3 cycles, then high.
   - Response: no key_valid; outputs unchanged; scanning resumes from column 2.
5. Held key with extras:
   - Stimulus: hold '0'. Press '3' meanwhile. Then the release bounces (high 3 cycles, low again) before the final release.
   - Response: exactly one key_valid; s_new=0.
6. Multi-row and reset:
   - Stimulus A: keys (r0,c2) and (r1,c2) held together.
   - Response A: no acceptance.
   - Stimulus B: reset=0 asserted at DEBOUNCE cycle 5 of '6'.
   - Response B: next cycle cols=1110, s_new=s_old=0, key_valid stays 0.
